load_store_unit: RTL and testbench

//  Sits between the core's execute stage and data_memory. Converts core load/store requests
//  (byte/half/word, signed/unsigned) into word-wide memory accesses.
//  Sub-word stores become read-modify-write sequences because memory has no byte enables.

---
 rtl/load_store_unit_if.sv | 26 ++
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core/memory-side bundle for load_store_unit.
// slave: the LSU itself; master: the environment (core request side plus data memory).
interface load_store_unit_if;
    logic        req_i;
    logic        we_i;
    logic [2:0]  size_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ack_o;
    logic        err_o;
    logic        mem_we_o;
    logic [31:0] mem_a_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;

    modport slave (
        input  req_i, we_i, size_i, addr_i, wdata_i, mem_rd_i,
        output rdata_o, ack_o, err_o, mem_we_o, mem_a_o, mem_wd_o
    );

    modport master (
        output req_i, we_i, size_i, addr_i, wdata_i, mem_rd_i,
        input  rdata_o, ack_o, err_o, mem_we_o, mem_a_o, mem_wd_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-wide data memory without byte enables.
// Sub-word stores run as read-modify-write; loads return lane-extracted, extended data.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- misaligned H/W accesses complete in one
// cycle with err_o=1 and no memory access. When undefined, err_o is 0 and misaligned low
// address bits are forced to alignment.
module load_store_unit #(
    parameter int unsigned MEM_AW = 6
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e              state_q, state_d;
    logic                we_q;
    logic [2:0]          size_q;
    logic [MEM_AW+1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         wd_q;
    logic [31:0]         rdata_q;
    logic                ack_q;

    // Request decode (IDLE-side, straight from the core inputs)
    logic                in_b, in_h, in_w;
    logic [1:0]          in_off;
    logic [MEM_AW+1:0]   addr_al;

    // Latched-request decode
    logic                q_b, q_h, q_uns;
    logic [7:0]          sel_byte;
    logic [15:0]         sel_half;
    logic [31:0]         load_val;
    logic [31:0]         merged;

    // Address bits above the memory are ignored, so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr_i[31:MEM_AW+2];

    // funct3 decode: only B/BU and H/HU are sub-word, everything else is a word access
    assign in_b = (bus.size_i[1:0] == 2'b00);
    assign in_h = (bus.size_i[1:0] == 2'b01);
    assign in_w = !in_b && !in_h;

    // Force misaligned low bits to the access alignment
    always_comb begin
        in_off = bus.addr_i[1:0];
        if (in_w) begin
            in_off = 2'b00;
        end else if (in_h) begin
            in_off = {bus.addr_i[1], 1'b0};
        end
    end
    assign addr_al = {bus.addr_i[MEM_AW+1:2], in_off};

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_i;
    logic err_d, err_q;
    assign misalign_i = (in_h && bus.addr_i[0]) || (in_w && (bus.addr_i[1:0] != 2'b00));
`endif

    assign q_b   = (size_q[1:0] == 2'b00);
    assign q_h   = (size_q[1:0] == 2'b01);
    assign q_uns = size_q[2];

    // Next-state selection
    always_comb begin
        state_d = state_q;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.req_i) begin
                    // Only full-word stores skip the read; sub-word stores need the old word
                    if (bus.we_i && in_w) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misalign_i) begin
                        state_d = StResp;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            StRead:  state_d = we_q ? StWrite : StResp;
            StWrite: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Lane extraction and extension of the word read from memory
    always_comb begin
        unique case (addr_q[1:0])
            2'b00:   sel_byte = bus.mem_rd_i[7:0];
            2'b01:   sel_byte = bus.mem_rd_i[15:8];
            2'b10:   sel_byte = bus.mem_rd_i[23:16];
            default: sel_byte = bus.mem_rd_i[31:24];
        endcase
        sel_half = addr_q[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
        if (q_b) begin
            load_val = {{24{sel_byte[7] & ~q_uns}}, sel_byte};
        end else if (q_h) begin
            load_val = {{16{sel_half[15] & ~q_uns}}, sel_half};
        end else begin
            load_val = bus.mem_rd_i;
        end
    end

    // Read-modify-write merge: replace only the target lane of the old word
    always_comb begin
        merged = bus.mem_rd_i;
        if (q_b) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (q_h) begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // State, request latch, write-data and load-result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            size_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            wd_q    <= 32'h0;
            rdata_q <= 32'h0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // ack is high exactly while in RESP
            ack_q   <= (state_d == StResp);
            if (state_q == StIdle && bus.req_i) begin
                we_q    <= bus.we_i;
                size_q  <= bus.size_i;
                addr_q  <= addr_al;
                wdata_q <= bus.wdata_i;
                if (bus.we_i && in_w) begin
                    wd_q <= bus.wdata_i;
                end
            end
            if (state_q == StRead) begin
                if (we_q) begin
                    wd_q <= merged;
                end else begin
                    rdata_q <= load_val;
                end
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Error flag accompanies the ack of a trapped access
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

    // Gating by rst_n keeps a reset from committing an in-flight write
    assign bus.mem_we_o = (state_q == StWrite) && rst_n;
    assign bus.mem_a_o  = (state_q == StIdle)
                        ? {{(32 - MEM_AW){1'b0}}, bus.addr_i[MEM_AW+1:2]}
                        : {{(32 - MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
    assign bus.mem_wd_o = wd_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.ack_o    = ack_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed requests, a transaction-level reference model
// (word array plus shift/mask lane arithmetic) and a per-cycle compare process.
module tb_load_store_unit;

    localparam int MAW = 6;

    logic clk;
    logic rst_n;
    logic mem_init;

    load_store_unit_if bus();

    load_store_unit #(.MEM_AW(MAW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment data memory: combinational read, write on posedge
    logic [31:0] tb_mem [64];
    assign bus.mem_rd_i = tb_mem[bus.mem_a_o[MAW-1:0]];

    function automatic logic [31:0] init_word(input int i);
        return 32'h9E3779B9 * (i + 1);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= init_word(i);
        end else if (bus.mem_we_o) begin
            tb_mem[bus.mem_a_o[MAW-1:0]] <= bus.mem_wd_o;
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state and per-transaction expectations
    logic [31:0] ref_mem [64];
    logic [31:0] m_rdata;
    int          exp_lat;
    bit          exp_wr, exp_rd, exp_err;
    logic [31:0] exp_idx, exp_wd, exp_rdata;

    function automatic void model(input logic we, input logic [2:0] sz,
                                  input logic [31:0] a, input logic [31:0] wd);
        int          n, o;
        bit          uns, mis;
        logic [31:0] mask, v, old;
        logic [MAW-1:0] idx;
        n   = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
        uns = (sz == 3'b100) || (sz == 3'b101);
        o   = int'(a[1:0]);
        idx = a[MAW+1:2];
        mis = (o % n) != 0;
        exp_idx = 32'(idx);
        exp_err = 1'b0;
        exp_wr  = 1'b0;
        exp_rd  = 1'b0;
        exp_wd  = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) begin
            exp_lat   = 1;
            exp_err   = 1'b1;
            exp_rdata = m_rdata;
            return;
        end
`else
        if (mis) o = o - (o % n);
`endif
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        if (!we) begin
            v = (ref_mem[idx] >> (8 * o)) & mask;
            if (!uns && n < 4 && v[8 * n - 1]) v = v | ~mask;
            m_rdata = v;
            exp_rd  = 1'b1;
            exp_lat = 2;
        end else if (n == 4) begin
            ref_mem[idx] = wd;
            exp_wd  = wd;
            exp_wr  = 1'b1;
            exp_lat = 2;
        end else begin
            old = ref_mem[idx];
            ref_mem[idx] = (old & ~(mask << (8 * o))) | ((wd & mask) << (8 * o));
            exp_wd  = ref_mem[idx];
            exp_wr  = 1'b1;
            exp_rd  = 1'b1;
            exp_lat = 3;
        end
        exp_rdata = m_rdata;
    endfunction

    // Shared with the compare process
    bit          active = 1'b0;
    bit          done   = 1'b0;
    int          cyc    = 0;
    int          seen_lat;
    logic [31:0] seen_wd;

    // Per-cycle compare, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("mem_we_in_reset", 32'(bus.mem_we_o), 32'd0);
        end else if (active) begin
            cyc++;
            chk("ack_timing", 32'(bus.ack_o), 32'(cyc == exp_lat));
            chk("mem_we_timing", 32'(bus.mem_we_o), 32'(exp_wr && (cyc == exp_lat - 1)));
            if (bus.mem_we_o) begin
                chk("wr_index", bus.mem_a_o, exp_idx);
                chk("wr_data", bus.mem_wd_o, exp_wd);
                seen_wd = bus.mem_wd_o;
            end
            if (exp_rd && cyc == 1) chk("rd_index", bus.mem_a_o, exp_idx);
            if (bus.ack_o) begin
                chk("rdata", bus.rdata_o, exp_rdata);
                chk("err", 32'(bus.err_o), 32'(exp_err));
                seen_lat = cyc;
                done     = 1'b1;
            end
        end else begin
            chk("idle_ack", 32'(bus.ack_o), 32'd0);
            chk("idle_mem_we", 32'(bus.mem_we_o), 32'd0);
        end
    end

    // Issue one request; called #1 after a posedge with the DUT in IDLE
    task automatic do_req(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input bit keep);
        model(we, sz, a, wd);
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.size_i  = sz;
        bus.addr_i  = a;
        bus.wdata_i = wd;
        @(posedge clk);
        #1;
        done   = 1'b0;
        cyc    = 0;
        active = 1'b1;
        // Post-accept input changes must be ignored
        bus.we_i    = 1'($urandom);
        bus.size_i  = 3'($urandom);
        bus.addr_i  = $urandom;
        bus.wdata_i = $urandom;
        for (int t = 0; t < 8 && !done; t++) begin
            @(posedge clk);
            #1;
        end
        if (!done) chk("ack_timeout", 32'd0, 32'd1);
        active = 1'b0;
        if (!keep) bus.req_i = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        m_rdata     = 32'h0;
        seen_wd     = 32'h0;
        seen_lat    = 0;
        mem_init    = 1'b1;
        rst_n       = 1'b0;
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.size_i  = 3'b010;
        bus.addr_i  = 32'h10;
        bus.wdata_i = 32'hFFFF_FFFF;

        // Reset with a store request pending
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_init  = 1'b0;
        bus.req_i = 1'b0;
        chk("rst_ack", 32'(bus.ack_o), 32'd0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_rdata", bus.rdata_o, 32'h0);
        chk("rst_mem_wd", bus.mem_wd_o, 32'h0);
        chk("rst_mem_a_idle", bus.mem_a_o, 32'd4);
        idle_cycle();

        // Word store then load
        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0);
        chk("sw_latency", 32'(seen_lat), 32'd2);
        idle_cycle();
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        chk("lw_latency", 32'(seen_lat), 32'd2);
        chk("lw_value", bus.rdata_o, 32'hDEAD_BEEF);
        idle_cycle();

        // Sub-word store over a known word
        do_req(1'b1, 3'b010, 32'h10, 32'h1122_3344, 1'b0);
        do_req(1'b1, 3'b000, 32'h13, 32'hFFFF_FF5A, 1'b0);
        chk("sb_merge", seen_wd, 32'h5A22_3344);
        chk("sb_latency", 32'(seen_lat), 32'd3);
        chk("sb_keeps_rdata", bus.rdata_o, 32'hDEAD_BEEF);
        idle_cycle();

        // Load extraction on 0x80FF7F01
        do_req(1'b1, 3'b010, 32'h10, 32'h80FF_7F01, 1'b0);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
        chk("lb", bus.rdata_o, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
        chk("lbu", bus.rdata_o, 32'h0000_0080);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
        chk("lh", bus.rdata_o, 32'hFFFF_80FF);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 1'b0);
        chk("lhu", bus.rdata_o, 32'h0000_80FF);

        // Misaligned word load
        do_req(1'b1, 3'b010, 32'h04, 32'hCAFE_F00D, 1'b0);
        do_req(1'b0, 3'b010, 32'h06, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_lw_latency", 32'(seen_lat), 32'd1);
        chk("mis_lw_rdata_kept", bus.rdata_o, 32'h0000_80FF);
`else
        chk("mis_lw_latency", 32'(seen_lat), 32'd2);
        chk("mis_lw_aligned", bus.rdata_o, 32'hCAFE_F00D);
`endif

        // Assorted: half store/load, misaligned HU, wrap, odd funct3 codes
        do_req(1'b1, 3'b001, 32'h16, 32'h1234_BEEF, 1'b0);
        do_req(1'b0, 3'b001, 32'h16, 32'h0, 1'b0);
        chk("sh_lh", bus.rdata_o, 32'hFFFF_BEEF);
        do_req(1'b0, 3'b101, 32'h17, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h0000_0110, 32'h0, 1'b0);
        chk("wrap_lw", bus.rdata_o, 32'h80FF_7F01);
        do_req(1'b1, 3'b011, 32'h20, 32'h0BAD_F00D, 1'b0);
        do_req(1'b0, 3'b111, 32'h20, 32'h0, 1'b0);
        chk("odd_funct3_word", bus.rdata_o, 32'h0BAD_F00D);
        do_req(1'b1, 3'b000, 32'h21, 32'h0000_00C3, 1'b0);
        do_req(1'b0, 3'b110, 32'h20, 32'h0, 1'b0);

        // Back-to-back: req held through RESP, next request accepted in the first IDLE
        idle_cycle();
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        do_req(1'b0, 3'b100, 32'h11, 32'h0, 1'b1);
        chk("b2b_lbu", bus.rdata_o, 32'h0000_007F);
        chk("b2b_latency", 32'(seen_lat), 32'd2);
        do_req(1'b1, 3'b000, 32'h10, 32'h0000_0099, 1'b0);
        chk("b2b_sb_latency", 32'(seen_lat), 32'd3);

        // Reset pulsed during WRITE of a sub-word store: no write, no ack
        idle_cycle();
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.size_i  = 3'b000;
        bus.addr_i  = 32'h11;
        bus.wdata_i = 32'h0000_0033;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        bus.req_i = 1'b0;
        m_rdata   = 32'h0;
        repeat (4) idle_cycle();
        chk("abort_rdata_cleared", bus.rdata_o, 32'h0);

        // Memory must match the model word for word
        for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), tb_mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
